// File: rtl/core_sequencer.sv
// Run-control FSM for the 9-bit core: start, per-instruction commit strobes, multi-cycle loads, halt.
// Strobes are Mealy outputs of the registered state and the current decode fields.
module core_sequencer #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned CNT_W        = 16,
  parameter logic [31:0] FLAG_OP_MASK = 32'h0000_00F0,
  parameter logic [31:0] WB_OP_MASK   = 32'h0000_FFFF,
  parameter logic [31:0] BR_OP_MASK   = 32'h0003_0000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             halt_req,
  input  logic [4:0]       op,
  input  logic             alu_rd,
  input  logic             alu_wr,
  input  logic             taken,
  output logic             pc_load,
  output logic             pc_en,
  output logic             branch_en,
  output logic             reg_we,
  output logic             flag_en,
  output logic             mem_re,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned     WAIT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LAT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam bit              HAS_WAIT  = (MEM_LAT != 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ins_q, ins_d;
  logic               cnt_clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_load   = 1'b0;
    pc_en     = 1'b0;
    branch_en = 1'b0;
    reg_we    = 1'b0;
    flag_en   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        pc_load = 1'b1;
        busy    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (halt_req) begin
          state_d = S_DONE;
        end else if (alu_rd && HAS_WAIT) begin
          // Load stalls the PC; op and alu_rd stay stable until the commit cycle.
          mem_re  = 1'b1;
          wait_d  = WAIT_LOAD;
          state_d = S_MEM_WAIT;
        end else begin
          pc_en     = 1'b1;
          branch_en = BR_OP_MASK[op] & taken;
          flag_en   = FLAG_OP_MASK[op];
          reg_we    = WB_OP_MASK[op] & ~alu_wr;
          mem_we    = alu_wr & ~alu_rd;
          mem_re    = alu_rd;
        end
      end
      S_MEM_WAIT: begin
        busy   = 1'b1;
        mem_re = 1'b1;
        wait_d = wait_q - WAIT_ONE;
        if (wait_q == WAIT_ONE) begin
          pc_en   = 1'b1;
          reg_we  = WB_OP_MASK[op];
          flag_en = FLAG_OP_MASK[op];
          state_d = S_EXEC;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters clear on the edge that launches a run and saturate instead of wrapping.
  always_comb begin
    cnt_clr = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    if (cnt_clr) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      if (busy && (cyc_q != {CNT_W{1'b1}})) cyc_d = cyc_q + CNT_W'(1);
      if (pc_en && (ins_q != {CNT_W{1'b1}})) ins_d = ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: three parameterisations driven in lockstep, checked against a run-level model.
module tb_core_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start, halt_req, alu_rd, alu_wr, taken;
  logic [4:0] op;

  // Per instance: {pc_load,pc_en,branch_en,reg_we,flag_en,mem_re,mem_we,busy,done}
  logic [8:0]  strb  [3];
  logic [15:0] cyc_o [3];
  logic [15:0] ins_o [3];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT_G = (g == 0) ? 1 : (g == 1) ? 2 : 0;
    localparam int unsigned CNT_G = (g == 2) ? 4 : 16;
    logic pl, pe, be, rw, fe, mr, mw, bz, dn;
    logic [CNT_G-1:0] cc, ic;
    core_sequencer #(.MEM_LAT(LAT_G), .CNT_W(CNT_G)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .halt_req(halt_req), .op(op),
      .alu_rd(alu_rd), .alu_wr(alu_wr), .taken(taken),
      .pc_load(pl), .pc_en(pe), .branch_en(be), .reg_we(rw), .flag_en(fe),
      .mem_re(mr), .mem_we(mw), .busy(bz), .done(dn),
      .cycle_cnt(cc), .instr_cnt(ic)
    );
    assign strb[g]  = {pl, pe, be, rw, fe, mr, mw, bz, dn};
    assign cyc_o[g] = 16'(cc);
    assign ins_o[g] = 16'(ic);
  end

  // Reference model: run status, pending load cycles and counters per instance.
  int lat_m [3] = '{1, 2, 0};
  int sat_m [3] = '{65535, 65535, 15};
  int m_run [3], m_halted [3], m_init [3], m_wait [3], m_cyc [3], m_ins [3];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_strb(input int k);
    logic [8:0] e;
    bit fl, wb, br;
    e  = '0;
    fl = (op >= 4) && (op <= 7);
    wb = (op < 16);
    br = (op == 16) || (op == 17);
    if (m_run[k] == 0) begin
      e[0] = (m_halted[k] != 0);
    end else if (m_init[k] != 0) begin
      e[8] = 1'b1;
      e[1] = 1'b1;
    end else if (m_wait[k] > 0) begin
      e[1] = 1'b1;
      e[3] = 1'b1;
      if (m_wait[k] == 1) begin
        e[7] = 1'b1;
        e[5] = wb;
        e[4] = fl;
      end
    end else begin
      e[1] = 1'b1;
      if (halt_req) begin
        e = e;
      end else if (alu_rd && lat_m[k] > 0) begin
        e[3] = 1'b1;
      end else begin
        e[7] = 1'b1;
        e[6] = br && taken;
        e[4] = fl;
        e[5] = wb && !alu_wr;
        e[2] = alu_wr && !alu_rd;
        e[3] = alu_rd;
      end
    end
    return e;
  endfunction

  function automatic int sat_inc(input int v, input int s);
    return (v >= s) ? s : v + 1;
  endfunction

  task automatic model_clock(input int k);
    if (m_run[k] == 0) begin
      if (start) begin
        m_run[k] = 1; m_init[k] = 1; m_halted[k] = 0; m_cyc[k] = 0; m_ins[k] = 0;
      end
    end else begin
      m_cyc[k] = sat_inc(m_cyc[k], sat_m[k]);
      if (m_init[k] != 0) begin
        m_init[k] = 0;
      end else if (m_wait[k] > 0) begin
        if (m_wait[k] == 1) m_ins[k] = sat_inc(m_ins[k], sat_m[k]);
        m_wait[k]--;
      end else if (halt_req) begin
        m_run[k] = 0; m_halted[k] = 1;
      end else if (alu_rd && lat_m[k] > 0) begin
        m_wait[k] = lat_m[k];
      end else begin
        m_ins[k] = sat_inc(m_ins[k], sat_m[k]);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_halted[k] = 0; m_init[k] = 0; m_wait[k] = 0; m_cyc[k] = 0; m_ins[k] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.strb%0d", tag, k), 16'(strb[k]), 16'(exp_strb(k)));
      chk($sformatf("%s.cyc%0d", tag, k), cyc_o[k], 16'(m_cyc[k]));
      chk($sformatf("%s.ins%0d", tag, k), ins_o[k], 16'(m_ins[k]));
    end
  endtask

  int stepno = 0;

  // Entered and left at posedge+1; outputs are sampled at the falling edge.
  task automatic step(input bit s, input bit h, input logic [4:0] o,
                      input bit rd, input bit wr, input bit tk);
    start = s; halt_req = h; op = o; alu_rd = rd; alu_wr = wr; taken = tk;
    @(negedge CLK);
    compare_all($sformatf("s%0d", stepno));
    @(posedge CLK);
    for (int k = 0; k < 3; k++) model_clock(k);
    stepno++;
    #1;
  endtask

  initial begin
    bit rd, wr;
    logic [4:0] o;
    int n;
    RST_N = 1'b0;
    start = 0; halt_req = 0; op = '0; alu_rd = 0; alu_wr = 0; taken = 0;
    model_reset();
    #2;
    compare_all("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Straight-line: start, INIT, op 4, 4, 1, halt.
    step(1, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd4, 0, 0, 0);
    step(0, 0, 5'd4, 0, 0, 0);
    step(0, 0, 5'd1, 0, 0, 0);
    step(0, 1, 5'd0, 0, 0, 0);
    chk("sl_cycle_cnt", cyc_o[0], 16'd5);
    chk("sl_instr_cnt", ins_o[0], 16'd3);
    chk("sl_done", 16'(strb[0][0]), 16'd1);
    step(0, 0, 5'd0, 0, 0, 0);

    // Load stall (held 3 cycles), store, branch taken/not taken, rd+wr, start while busy.
    step(1, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 5'd2, 1, 0, 0);
    chk("ld2_cycle_cnt", cyc_o[1], 16'd4);
    chk("ld2_instr_cnt", ins_o[1], 16'd1);
    step(0, 0, 5'd3, 0, 1, 0);
    step(0, 0, 5'd16, 0, 0, 1);
    step(0, 0, 5'd16, 0, 0, 0);
    step(0, 0, 5'd5, 1, 1, 0);
    step(0, 0, 5'd5, 1, 1, 0);
    step(1, 0, 5'd1, 0, 0, 0);
    step(0, 1, 5'd0, 0, 0, 0);
    step(0, 1, 5'd0, 0, 0, 0);
    step(0, 1, 5'd0, 0, 0, 0);

    // Mid-run reset during a store: strobes must drop immediately.
    step(1, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd1, 0, 0, 0);
    start = 0; halt_req = 0; op = 5'd3; alu_rd = 0; alu_wr = 1; taken = 0;
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("pre_rst_mem_we%0d", k), 16'(strb[k][2]), 16'd1);
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all("in_rst");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 5'($urandom_range(31)), 0, 0, 0);

    // Randomised programs long enough to saturate the 4-bit counters.
    for (int r = 0; r < 3; r++) begin
      step(1, 0, 5'd0, 0, 0, 0);
      chk($sformatf("restart_cyc_r%0d", r), cyc_o[2], 16'd0);
      chk($sformatf("restart_ins_r%0d", r), ins_o[2], 16'd0);
      step(0, 0, 5'd0, 0, 0, 0);
      n = 20 + $urandom_range(10);
      for (int i = 0; i < n; i++) begin
        o  = 5'($urandom_range(31));
        rd = ($urandom_range(3) == 0);
        wr = ($urandom_range(3) == 0);
        if (rd) begin
          for (int j = 0; j < 3; j++) step(0, 0, o, 1, wr, 1'($urandom_range(1)));
        end else begin
          step(1'($urandom_range(7) == 0), 0, o, 0, wr, 1'($urandom_range(1)));
        end
      end
      for (int j = 0; j < 3; j++) step(0, 1, 5'd0, 0, 0, 0);
      chk($sformatf("sat_cyc_r%0d", r), cyc_o[2], 16'd15);
      chk($sformatf("sat_ins_r%0d", r), ins_o[2], 16'd15);
      step(0, 0, 5'd0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
